tt_um_mac_pipe: RTL
===================

// Module: tt_um_mac_pipe
// PURPOSE
//  Parametrised, fully pipelined multiply-accumulate unit; successor to the fixed 4x4/8-bit MAC.
//  Accepts one A*B operand pair per cycle under a valid strobe and accumulates into an ACC_W-bit register.
//  Supports a signed/unsigned build option, runtime wrap or saturate, and per-sample clear.
//  Reports a sticky overflow flag and a term counter.
//  Sits between the pad-level operand capture and the result output mux of the tile top.
// PARAMETERS
//  IN_W    4   operand width, A and B, bits; >= 2
//  ACC_W   8   accumulator width; ACC_W >= 2*IN_W (elaboration error otherwise)
//  SIGNED  0   0 = unsigned operands/acc, 1 = two's-complement operands/acc
//  CNT_W   4   term-counter width
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair a/b valid this cycle; no backpressure, accepted every cycle
//  in_clear   in   1      start new accumulation (see BEHAVIOUR)
//  sat_en     in   1      1 = saturating add, 0 = modular wrap; sampled with operands
//  a          in   IN_W   multiplicand
//  b          in   IN_W   multiplier
//  acc_out    out  ACC_W  accumulator value (registered)
//  out_valid  out  1      one-cycle pulse: acc_out updated this cycle
//  overflow   out  1      sticky: an add overflowed (wrapped or clipped) since last clear
//  term_cnt   out  CNT_W  products accumulated since last clear; saturates at all-ones
// BEHAVIOUR
//  Reset: acc_out=0, out_valid=0, overflow=0, term_cnt=0, all pipeline valid/clear/sat bits=0.
//  Reset mid-operation discards in-flight samples.
//  Stage 1 (edge k): register prod = a*b (2*IN_W bits, signed if SIGNED), v1=in_valid, c1=in_clear, s1=sat_en.
//  Stage 2 (edge k+1): update acc; out_valid=v1 for that cycle. Latency 2 edges; throughput 1/cycle.
//  The acc feedback is a single-cycle loop. Back-to-back samples need no bubble: each add sees the previous sum.
//  Product is extended to ACC_W: zero-extended if SIGNED=0, sign-extended if SIGNED=1.
//  v1=1, c1=0: acc <= acc + ext(prod); term_cnt += 1 (saturating).
//  v1=1, c1=1: acc <= ext(prod); term_cnt <= 1; overflow <= 0.
//  v1=0, c1=1: acc <= 0; term_cnt <= 0; overflow <= 0; out_valid=0.
//  v1=0, c1=0: hold all state; out_valid=0.
//  Overflow detection:
//   - unsigned: carry out of ACC_W.
//   - signed: operands same sign and result sign differs.
//  On overflow with s1=1: clamp.
//   - unsigned: to 2^ACC_W-1.
//   - signed: to max positive / min negative, matching the operand sign.
//  On overflow with s1=0: keep the wrapped ACC_W-bit sum.
//  Either way overflow <= 1 (sticky until a clear or reset).
//  Loading a product on clear can never overflow (ACC_W >= 2*IN_W).
//  Once saturated, acc stays clamped until the added product moves it back in range (e.g. a negative product, signed).
// STRUCTURE
//  Package mac_pkg: localparam helpers ACC_MAX/ACC_MIN functions of ACC_W/SIGNED, and ext_prod() extend function.
//  Sub-module mac_sat_add: combinational ACC_W adder with sat_en and SIGNED param -> sum, ovf.
//  Top holds both pipeline stages, the counter and the sticky flag.
// TESTING
//  1. Defaults, unsigned. After reset, apply (3,5), (2,7), (15,15) valid back-to-back with no clear.
//     -> acc_out 15, 29, 254; out_valid three consecutive cycles starting 2 edges after the first; overflow=0; term_cnt=3.
//  2. Unsigned, sat_en=0. From acc=254, add (1,3). -> acc_out=1, overflow=1.
//     Repeat with sat_en=1 -> acc_out=255, overflow=1.
//     A following in_clear with (2,2) -> acc_out=4, overflow=0, term_cnt=1.
//  3. SIGNED=1, sat_en=1. Accumulate (-8,-8) twice. -> 64, then 127 clamped, overflow=1.
//     Then (-8,7) -> 71.
//  4. Throughput. Gaps (in_valid low) between samples. -> acc held and out_valid low in gap cycles.
//     in_clear with in_valid=0 -> acc_out=0, term_cnt=0.
//  5. Assert rst_n low for one cycle mid-stream with samples in both stages.
//     -> all outputs 0 asynchronously; no out_valid pulse afterwards for the discarded samples.
//  6. CNT_W=4. Feed 20 valid (0,0) samples. -> term_cnt sticks at 15; acc_out=0; overflow=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the pipelined multiply-accumulate unit.
// Functions work on a wide scratch vector; callers size the result down.
package mac_pkg;

  localparam int MAX_W = 64;

  // Largest representable accumulator value: all ones, or 0111..1 when signed.
  function automatic logic [MAX_W-1:0] acc_max(input int acc_w, input bit is_signed);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < acc_w - (is_signed ? 1 : 0)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest representable accumulator value: zero, or 1000..0 when signed.
  function automatic logic [MAX_W-1:0] acc_min(input int acc_w, input bit is_signed);
    logic [MAX_W-1:0] r;
    r = '0;
    if (is_signed) r[acc_w-1] = 1'b1;
    return r;
  endfunction

  // Extend a prod_w-bit product to full scratch width (zero or sign fill).
  function automatic logic [MAX_W-1:0] ext_prod(input logic [MAX_W-1:0] prod,
                                                input int prod_w, input bit is_signed);
    logic [MAX_W-1:0] r;
    r = prod;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= prod_w) r[i] = is_signed & prod[prod_w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator adder with overflow detect and optional clamp.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  input  logic             sat_en_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W, SIGNED != 0));

  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] clamp;

  // Add, flag overflow, and pick the wrapped or clamped result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    raw   = {1'b0, a_i} + {1'b0, b_i};
    ovf_o = 1'b0;
    clamp = MAX_V;
    if (SIGNED != 0) begin
      ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
      clamp = a_i[ACC_W-1] ? MIN_V : MAX_V;
    end else begin
      ovf_o = raw[ACC_W];
    end
    sum_o = (ovf_o && sat_en_i) ? clamp : raw[ACC_W-1:0];
  end

endmodule

// File: rtl/tt_um_mac_pipe.sv
// Two-stage pipelined multiply-accumulate: stage 1 registers the product,
// stage 2 folds it into the accumulator with wrap or saturate.
module tt_um_mac_pipe
  import mac_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_clear,
  input  logic             sat_en,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             overflow,
  output logic [CNT_W-1:0] term_cnt
);

  localparam int PROD_W = 2 * IN_W;

  if (IN_W < 2) begin : g_bad_in_w
    $error("tt_um_mac_pipe: IN_W must be >= 2");
  end
  if (ACC_W < PROD_W || ACC_W > MAX_W) begin : g_bad_acc_w
    $error("tt_um_mac_pipe: ACC_W must be in [2*IN_W, 64]");
  end

  // Stage 1 state
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              v1_q, c1_q, s1_q;

  // Stage 2 state
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              out_valid_q;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PROD_W-1:0] a_ext, b_ext;
  logic [ACC_W-1:0]  prod_ext, sum;
  logic              add_ovf;

  // Operands widened to product width so the low half of the product is exact.
  always_comb begin
    a_ext  = {{IN_W{(SIGNED != 0) && a[IN_W-1]}}, a};
    b_ext  = {{IN_W{(SIGNED != 0) && b[IN_W-1]}}, b};
    prod_d = a_ext * b_ext;
  end

  // Stage 1 register: product plus the sample's control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      prod_q <= '0;
      v1_q   <= 1'b0;
      c1_q   <= 1'b0;
      s1_q   <= 1'b0;
    end else begin
      prod_q <= prod_d;
      v1_q   <= in_valid;
      c1_q   <= in_clear;
      s1_q   <= sat_en;
    end
  end

  assign prod_ext = ACC_W'(ext_prod(MAX_W'(prod_q), PROD_W, SIGNED != 0));

  mac_sat_add #(
    .ACC_W (ACC_W),
    .SIGNED(SIGNED)
  ) u_add (
    .a_i     (acc_q),
    .b_i     (prod_ext),
    .sat_en_i(s1_q),
    .sum_o   (sum),
    .ovf_o   (add_ovf)
  );

  // Stage 2 next state: clear/load, accumulate, or hold.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (c1_q) begin
      acc_d = v1_q ? prod_ext : '0;
      cnt_d = v1_q ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (v1_q) begin
      acc_d = sum;
      ovf_d = ovf_q | add_ovf;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stage 2 register: accumulator, sticky flag, counter and output strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= v1_q;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign acc_out   = acc_q;
  assign out_valid = out_valid_q;
  assign overflow  = ovf_q;
  assign term_cnt  = cnt_q;

endmodule
